// File: rtl/cache_refill_ctrl.sv
// Read-miss refill controller: stalls the CPU, bursts one cache line from backing memory, streams it into the array.
// Optional feature: define MISS_COUNTER_EN for a saturating serviced-miss counter on miss_count.
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re,
  input  logic                  hit,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  stall,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  refill_done,
  output logic [15:0]           miss_count
);
  localparam int OFS = $clog2(LINE_WORDS);
  localparam logic [OFS-1:0] LAST_WORD = OFS'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    state_r;
  state_t                    state_nxt_s;
  logic [ADDR_WIDTH-OFS-1:0] line_tag_r;
  logic [OFS-1:0]            word_cnt_r;
  logic [ADDR_WIDTH-1:0]     word_addr_s;
  logic                      stall_s;
  logic                      mem_req_s;
  logic                      done_s;
  logic                      accept_s;
  logic                      capture_s;
  logic                      last_word_s;
  logic                      fill_we_r;
  logic [ADDR_WIDTH-1:0]     fill_addr_r;
  logic [DATA_WIDTH-1:0]     fill_data_r;

  // The word offset only ever replaces the zeroed low bits, so no carry can reach the tag.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-OFS-1:0] tag,
                                                      input logic [OFS-1:0]            cnt);
    return {tag, cnt};
  endfunction

  assign word_addr_s = beat_addr(line_tag_r, word_cnt_r);
  assign last_word_s = (word_cnt_r == LAST_WORD);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    mem_req_s   = 1'b0;
    done_s      = 1'b0;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        stall_s = re & ~hit;
        if (re && !hit) begin
          accept_s    = 1'b1;
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        stall_s   = 1'b1;
        mem_req_s = 1'b1;
        if (mem_ready) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        stall_s = 1'b1;
        if (mem_rvalid) begin
          capture_s   = 1'b1;
          state_nxt_s = last_word_s ? DONE : REQ;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE: begin
        stall_s     = 1'b1;
        done_s      = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Line address, beat counter and the one-cycle-delayed fill port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_tag_r  <= {(ADDR_WIDTH-OFS){1'b0}};
      word_cnt_r  <= {OFS{1'b0}};
      fill_we_r   <= 1'b0;
      fill_addr_r <= {ADDR_WIDTH{1'b0}};
      fill_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      fill_we_r <= capture_s;
      if (accept_s) begin
        line_tag_r <= addr[ADDR_WIDTH-1:OFS];
        word_cnt_r <= {OFS{1'b0}};
      end else if (capture_s && !last_word_s) begin
        word_cnt_r <= word_cnt_r + OFS'(1);
      end
      if (capture_s) begin
        fill_addr_r <= word_addr_s;
        fill_data_r <= mem_rdata;
      end
    end
  end

  assign stall       = stall_s;
  assign mem_req     = mem_req_s;
  assign mem_addr    = mem_req_s ? word_addr_s : {ADDR_WIDTH{1'b0}};
  assign refill_done = done_s;
  assign fill_we     = fill_we_r;
  assign fill_addr   = fill_addr_r;
  assign fill_data   = fill_data_r;

`ifdef MISS_COUNTER_EN
  logic [15:0] miss_count_r;

  // Serviced-miss counter; sticks at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_count_r <= 16'h0000;
    end else if (accept_s && (miss_count_r != 16'hFFFF)) begin
      miss_count_r <= miss_count_r + 16'd1;
    end
  end

  assign miss_count = miss_count_r;
`else
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: randomized memory timing, line-level reference model, decoupled monitor.
module tb_cache_refill_ctrl;
  localparam int LW = 4;

  logic       clk;
  logic       rst;
  logic       re;
  logic       hit;
  logic [7:0] addr;
  logic       stall;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready;
  logic       mem_rvalid;
  logic [7:0] mem_rdata;
  logic       fill_we;
  logic [7:0] fill_addr;
  logic [7:0] fill_data;
  logic       refill_done;
  logic [15:0] miss_count;

  cache_refill_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .re(re), .hit(hit), .addr(addr),
    .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
    .refill_done(refill_done), .miss_count(miss_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int fill_cnt = 0;
  int miss_cyc = 0;
  int misses = 0;
  int lat;

  logic [7:0] mem_arr [256];
  logic [7:0] exp_req_q[$];
  logic [7:0] exp_fa_q[$];
  logic [7:0] exp_fd_q[$];

  // memory model knobs and state
  int rdy_min = 0, rdy_max = 0, rv_min = 0, rv_max = 0;
  bit junk_en = 1'b0;
  bit pend = 1'b0;
  logic [7:0] pend_addr;
  int rv_left = 0;
  int rdy_left = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_fill_we"}, 32'(fill_we), 32'd0);
    chk({tag, "_fill_addr"}, 32'(fill_addr), 32'd0);
    chk({tag, "_fill_data"}, 32'(fill_data), 32'd0);
    chk({tag, "_refill_done"}, 32'(refill_done), 32'd0);
    chk({tag, "_miss_count"}, 32'(miss_count), 32'd0);
  endtask

  // Reference: a miss on address a must fetch and fill every word of its aligned line, in order.
  task automatic start_miss(input logic [7:0] a);
    int base;
    re = 1'b1; hit = 1'b0; addr = a;
    base = (int'(a) / LW) * LW;
    for (int i = 0; i < LW; i++) begin
      exp_req_q.push_back(8'(base + i));
      exp_fa_q.push_back(8'(base + i));
      exp_fd_q.push_back(mem_arr[base + i]);
    end
    miss_cyc = cyc;
    misses++;
    #1;
    chk("stall_on_miss", 32'(stall), 32'd1);
    chk("no_req_in_idle", 32'(mem_req), 32'd0);
  endtask

  // Returns in the IDLE cycle right after refill_done; busy-time inputs are scrambled.
  task automatic wait_done(output int latency);
    int start = done_cnt;
    int n = 0;
    latency = 0;
    forever begin
      @(posedge clk); #1;
      if (done_cnt != start) break;
      if (n >= 500) begin
        chk("refill_timeout", 32'(done_cnt), 32'(start + 1));
        break;
      end
      re = 1'($urandom); hit = 1'($urandom); addr = 8'($urandom);
      n++;
    end
    latency = done_cyc - miss_cyc + 1;
  endtask

  // Memory model: random ready backpressure, random read latency, optional junk rvalid.
  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'($urandom);
      if (pend) begin
        if (rv_left == 0) begin
          mem_rvalid = 1'b1; mem_rdata = mem_arr[pend_addr]; pend = 1'b0;
        end else begin
          rv_left--;
        end
      end else if (junk_en && ($urandom_range(3, 0) == 0)) begin
        mem_rvalid = 1'b1;
      end
      if (rst && mem_req && !pend) begin
        if (rdy_left < 0) rdy_left = int'($urandom_range(rdy_max, rdy_min));
        if (rdy_left == 0) begin
          mem_ready = 1'b1; pend = 1'b1; pend_addr = mem_addr;
          rv_left = int'($urandom_range(rv_max, rv_min)); rdy_left = -1;
        end else begin
          rdy_left--;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a request, fill or completion.
  initial begin
    bit hold_chk = 1'b0;
    logic [7:0] hold_addr = 8'h00;
    forever begin
      @(negedge clk); #3;
      if (!rst) begin
        hold_chk = 1'b0;
      end else begin
        if (hold_chk) begin
          chk("req_held", 32'(mem_req), 32'd1);
          chk("req_addr_held", 32'(mem_addr), 32'(hold_addr));
        end
        hold_chk = mem_req && !mem_ready;
        hold_addr = mem_addr;
        if (mem_req && mem_ready) begin
          if (exp_req_q.size() == 0) chk("unexpected_mem_req", 32'(mem_addr), 32'hFFFF_FFFF);
          else chk("mem_addr", 32'(mem_addr), 32'(exp_req_q.pop_front()));
        end
        if (fill_we) begin
          fill_cnt++;
          if (exp_fa_q.size() == 0) begin
            chk("unexpected_fill_we", 32'(fill_addr), 32'hFFFF_FFFF);
          end else begin
            chk("fill_addr", 32'(fill_addr), 32'(exp_fa_q.pop_front()));
            chk("fill_data", 32'(fill_data), 32'(exp_fd_q.pop_front()));
          end
        end
        if (refill_done) begin
          chk("done_with_line_filled", 32'(exp_fa_q.size()), 32'd0);
          chk("done_with_reqs_issued", 32'(exp_req_q.size()), 32'd0);
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    int n;
    int fstart;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
    mem_arr[8'h34] = 8'hA0; mem_arr[8'h35] = 8'hA1;
    mem_arr[8'h36] = 8'hA2; mem_arr[8'h37] = 8'hA3;
    rst = 1'b0; re = 1'b0; hit = 1'b0; addr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b1;

    // single miss, immediate memory
    start_miss(8'h37);
    wait_done(lat);
    chk("single_miss_latency", 32'(lat), 32'd10);
    re = 1'b1; hit = 1'b1; #1;
    chk("stall_low_after_done", 32'(stall), 32'd0);

    // hits only
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      re = 1'b1; hit = 1'b1; addr = 8'($urandom); #1;
      chk("hit_quiet", {29'd0, stall, mem_req, fill_we}, 32'd0);
    end

    // backpressure: ready low 3 cycles per request
    @(posedge clk); #1;
    rdy_min = 3; rdy_max = 3;
    start_miss(8'h81);
    wait_done(lat);
    chk("backpressure_latency", 32'(lat), 32'd22);

    // back-to-back misses
    rdy_min = 0; rdy_max = 0;
    start_miss(8'h10);
    wait_done(lat);
    start_miss(8'h24);
    @(posedge clk); #1;
    chk("b2b_req_2_after_done", 32'(mem_req), 32'd1);
    chk("b2b_req_addr", 32'(mem_addr), 32'h24);
    wait_done(lat);
    chk("b2b_second_latency", 32'(lat), 32'd10);

    // reset in the WAIT of word 2
    rv_min = 3; rv_max = 3;
    start_miss(8'h5A);
    fstart = fill_cnt; n = 0;
    while (fill_cnt < fstart + 2 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("reached_word2", 32'(fill_cnt - fstart), 32'd2);
    chk("in_wait_stall", {30'd0, stall, mem_req}, 32'd2);
    re = 1'b0; hit = 1'b0;
    #1 rst = 1'b0;
    #1 chk_zero("async_reset");
    exp_req_q.delete(); exp_fa_q.delete(); exp_fd_q.delete();
    pend = 1'b0; rdy_left = -1; misses = 0;
    @(posedge clk); #1;
    chk_zero("reset_next_cycle");
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("no_fill_after_reset", {30'd0, fill_we, mem_req}, 32'd0);
    end

    // randomized traffic
    rdy_min = 0; rdy_max = 3; rv_min = 0; rv_max = 3; junk_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      int gap = int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) begin
        re = 1'($urandom); hit = 1'b1; addr = 8'($urandom);
        #1;
        chk("stall_on_hit", 32'(stall), 32'd0);
        @(posedge clk); #1;
      end
      start_miss(8'($urandom));
      wait_done(lat);
    end
    re = 1'b0; hit = 1'b0; junk_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_req_q.size() + exp_fa_q.size()), 32'd0);
`ifdef MISS_COUNTER_EN
    chk("miss_count", 32'(miss_count), 32'((misses > 65535) ? 65535 : misses));
`else
    chk("miss_count_tied", 32'(miss_count), 32'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
